// File: rtl/ide_pkg.sv
// ide_pkg
//   Shared definitions for the IDE front end: the data register address
//   decode, the default sector size and the sector buffer state type.
package ide_pkg;

  // {cs,da} value selecting the 16-bit IDE data register
  localparam logic [4:0] DATA_REG_ADDR = 5'b01000;

  // One GD-ROM sector in bytes
  localparam int SECTOR_BYTES = 2048;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DRAIN
  } sbuf_state_t;

endpackage

// File: rtl/ide_strobe_sync.sv
// ide_strobe_sync
//   Brings the raw IDE read strobe and address lines into the clk domain
//   and flags the rising (end-of-strobe) edge of the strobe.
//   Written generically so the DIOW path can reuse it.
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   rd         raw active-low strobe, asynchronous to clk
//   addr       raw {cs,da} address lines, asynchronous to clk
//   rd_rise    one-cycle pulse: synchronized strobe went low -> high
//   addr_sync  address after the same two-flop delay as the strobe, so it
//              lines up with rd_rise
module ide_strobe_sync #(
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          rd,
  input  logic [AW-1:0] addr,
  output logic          rd_rise,
  output logic [AW-1:0] addr_sync
);

  // rd_sh[0..1] are the synchronizer, rd_sh[2] is the edge-detect history
  logic [2:0]    rd_sh_reg;
  logic [AW-1:0] addr_meta_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // Strobe idles high; resetting to 1 avoids a false edge on release
      rd_sh_reg     <= 3'b111;
      addr_meta_reg <= '0;
      addr_sync     <= '0;
    end else begin
      rd_sh_reg     <= {rd_sh_reg[1:0], rd};
      addr_meta_reg <= addr;
      addr_sync     <= addr_meta_reg;
    end
  end

  assign rd_rise = rd_sh_reg[1] & ~rd_sh_reg[2];

endmodule

// File: rtl/ide_sector_buffer.sv
// ide_sector_buffer
//   Stages one host transfer (up to one sector) between the UART receive
//   path and the IDE data register. Bytes are packed little-endian into
//   16-bit words, then drained one word per DIOR strobe at the data
//   register address.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   load_start          pulse: latch xfer_len and (re)start a load
//   xfer_len            byte count, 0 selects a full sector
//   rx_data, rx_valid   byte stream from the UART receiver
//   cs, da, rd          raw IDE chip selects, address and DIOR
//   rd_word             word driven to the data pins (mem[rd_ptr])
//   data_ready          buffer holds a complete transfer
//   done                pulse after the last word has been read
//   overrun             sticky: byte arrived while not filling
//   checksum            running byte sum (only with IDE_SECTOR_CHKSUM_EN)
//
// Build option: define IDE_SECTOR_CHKSUM_EN to build the checksum adder;
// otherwise checksum reads as zero.
module ide_sector_buffer #(
  parameter int SECTOR_BYTES = ide_pkg::SECTOR_BYTES,
  parameter int DEPTH_WORDS  = SECTOR_BYTES / 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load_start,
  input  logic [15:0] xfer_len,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic [1:0]  cs,
  input  logic [2:0]  da,
  input  logic        rd,
  output logic [15:0] rd_word,
  output logic        data_ready,
  output logic        done,
  output logic        overrun,
  output logic [15:0] checksum
);
  import ide_pkg::*;

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = 12;

  sbuf_state_t   state_reg;
  logic [CW-1:0] target_reg, words_reg, byte_cnt_reg, rd_cnt_reg;
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [7:0]    lo_byte_reg;
  logic          data_ready_reg, done_reg, overrun_reg;
  // rd_word must read 0 until word 0 has been written since reset; the
  // second flag waits one extra cycle for the read-first RAM output.
  logic          mem0_written_reg, mem0_valid_reg;

  logic [15:0]   mem [DEPTH_WORDS];
  logic [15:0]   mem_q;

  logic          rd_rise;
  logic [4:0]    addr_sync;

  logic [CW-1:0] len_clamped;
  logic          accept, last_byte, wr_en, rd_adv;
  logic [15:0]   wr_data;

  ide_strobe_sync #(.AW(5)) u_strobe_sync (
    .clk       (clk),
    .reset_n   (reset_n),
    .rd        (rd),
    .addr      ({cs, da}),
    .rd_rise   (rd_rise),
    .addr_sync (addr_sync)
  );

  always_comb begin
    len_clamped = CW'(SECTOR_BYTES);
    if (xfer_len != 16'd0 && xfer_len <= 16'(SECTOR_BYTES))
      len_clamped = xfer_len[CW-1:0];
  end

  // A load_start in the same cycle always wins over a byte or strobe
  assign accept    = (state_reg == FILL) && rx_valid && !load_start;
  assign last_byte = (byte_cnt_reg + CW'(1)) == target_reg;
  // Write on the odd byte, or early on the final byte of an odd transfer
  assign wr_en     = accept && (byte_cnt_reg[0] || last_byte);
  assign wr_data   = byte_cnt_reg[0] ? {rx_data, lo_byte_reg} : {8'h00, rx_data};
  assign rd_adv    = (state_reg == DRAIN) && rd_rise &&
                     (addr_sync == DATA_REG_ADDR) && !load_start;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg        <= IDLE;
      target_reg       <= '0;
      words_reg        <= '0;
      byte_cnt_reg     <= '0;
      rd_cnt_reg       <= '0;
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      lo_byte_reg      <= '0;
      data_ready_reg   <= 1'b0;
      done_reg         <= 1'b0;
      overrun_reg      <= 1'b0;
      mem0_written_reg <= 1'b0;
      mem0_valid_reg   <= 1'b0;
    end else begin
      done_reg         <= 1'b0;
      mem0_written_reg <= mem0_written_reg | (wr_en && wr_ptr_reg == '0);
      mem0_valid_reg   <= mem0_valid_reg | mem0_written_reg;
      if (load_start) begin
        state_reg      <= FILL;
        target_reg     <= len_clamped;
        words_reg      <= (len_clamped + CW'(1)) >> 1;
        byte_cnt_reg   <= '0;
        rd_cnt_reg     <= '0;
        wr_ptr_reg     <= '0;
        rd_ptr_reg     <= '0;
        data_ready_reg <= 1'b0;
        overrun_reg    <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (rx_valid) overrun_reg <= 1'b1;
          end
          FILL: begin
            if (accept) begin
              byte_cnt_reg <= byte_cnt_reg + CW'(1);
              if (!byte_cnt_reg[0]) lo_byte_reg <= rx_data;
              if (wr_en) wr_ptr_reg <= wr_ptr_reg + AW'(1);
              if (last_byte) begin
                state_reg      <= DRAIN;
                data_ready_reg <= 1'b1;
              end
            end
          end
          DRAIN: begin
            if (rx_valid) overrun_reg <= 1'b1;
            if (rd_adv) begin
              if ((rd_cnt_reg + CW'(1)) == words_reg) begin
                // Park on word 0 so IDLE presents mem[0] of this load
                rd_ptr_reg     <= '0;
                rd_cnt_reg     <= '0;
                done_reg       <= 1'b1;
                data_ready_reg <= 1'b0;
                state_reg      <= IDLE;
              end else begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
                rd_cnt_reg <= rd_cnt_reg + CW'(1);
              end
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  // Block RAM: one write port, one registered read port
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg] <= wr_data;
    mem_q <= mem[rd_ptr_reg];
  end

  assign rd_word    = mem0_valid_reg ? mem_q : 16'h0000;
  assign data_ready = data_ready_reg;
  assign done       = done_reg;
  assign overrun    = overrun_reg;

`ifdef IDE_SECTOR_CHKSUM_EN
  logic [15:0] chk_reg;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        chk_reg <= 16'h0000;
    else if (load_start) chk_reg <= 16'h0000;
    else if (accept)     chk_reg <= chk_reg + {8'h00, rx_data};
  end
  assign checksum = chk_reg;
`else
  assign checksum = 16'h0000;
`endif

endmodule
